ring_buffer_arbiter: RTL and testbench



---
 rtl/rb_arb_pkg.sv | 23 ++
 rtl/ring_buffer_arbiter_rr_pick.sv | 40 ++++
 rtl/ring_buffer_arbiter.sv | 129 ++++++++++++
 tb/tb_ring_buffer_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rb_arb_pkg.sv
// Shared types and helpers for the ring-buffer write-port arbiter.
// Optional per-requester transfer statistics are enabled by RB_ARB_STATS_EN.
package rb_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int STATS_W = 16;
  localparam int MAX_REQ = 16;

  // One-hot to binary index; an all-zero vector maps to index 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_buffer_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after the
// priority pointer, wrapping modulo N_REQ.
module rr_pick
  import rb_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic             valid
);

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p,
                                                input int unsigned    off);
    logic [IDX_W:0] s;
    s = {1'b0, p} + (IDX_W+1)'(off);
    if (s >= (IDX_W+1)'(N_REQ)) s = s - (IDX_W+1)'(N_REQ);
    return s[IDX_W-1:0];
  endfunction

  logic [IDX_W-1:0] idx;

  // NOTE: every signal written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = wrap_add(ptr, i);
      if (!valid && req[idx]) begin
        grant[idx] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ring_buffer_arbiter.sv
// Round-robin arbiter sharing one ring-buffer write port among N_REQ producers.
// Define RB_ARB_STATS_EN to add per-requester accepted-transfer counters.
module ring_buffer_arbiter
  import rb_arb_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic [N_REQ-1:0]                req_i,
  output logic [N_REQ-1:0]                ack_o,
  input  logic [N_REQ-1:0][DATA_SIZE-1:0] data_i,
  output logic                            tx_o,
  input  logic                            tx_ack_i,
  output logic [DATA_SIZE-1:0]            data_o,
  output logic [N_REQ-1:0]                grant_o
`ifdef RB_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][STATS_W-1:0]   xfer_cnt_o
`endif
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;

  logic [N_REQ-1:0] pick_grant;
  logic             pick_valid;
  logic [3:0]       g_raw;
  logic [IDX_W-1:0] g_idx;
  logic [IDX_W-1:0] ptr_next;
  logic             in_burst;
  logic             req_g;
  logic             xfer;
  logic             limit_hit;
  logic             release_burst;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (req_i),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  assign g_raw    = onehot_to_idx(MAX_REQ'(grant_q));
  assign g_idx    = g_raw[IDX_W-1:0];
  assign in_burst = (state_q == BURST);
  assign req_g    = req_i[g_idx];
  assign ptr_next = (g_idx == IDX_W'(N_REQ - 1)) ? '0 : g_idx + IDX_W'(1);

  // A flush cycle never moves data: ack is suppressed before it reaches a producer.
  assign xfer          = in_burst && req_g && tx_ack_i && !flush_i;
  assign limit_hit     = (MAX_BURST != 0) && (cnt_q == CNT_W'(MAX_BURST - 1));
  assign release_burst = in_burst && (!req_g || (xfer && limit_hit));

  always_comb begin
    tx_o    = 1'b0;
    ack_o   = '0;
    data_o  = '0;
    grant_o = '0;
    if (in_burst) begin
      tx_o    = req_g;
      data_o  = data_i[g_idx];
      grant_o = grant_q;
      ack_o   = grant_q & {N_REQ{tx_ack_i && !flush_i}};
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_grant;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (release_burst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= ptr_next;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RB_ARB_STATS_EN
  logic [N_REQ-1:0][STATS_W-1:0] xfer_cnt_q;

  // Counters wrap naturally at 2^STATS_W.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      xfer_cnt_q <= '0;
    end else if (flush_i) begin
      xfer_cnt_q <= '0;
    end else if (xfer) begin
      xfer_cnt_q[g_idx] <= xfer_cnt_q[g_idx] + STATS_W'(1);
    end
  end

  assign xfer_cnt_o = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_ring_buffer_arbiter.sv
// Self-checking bench for ring_buffer_arbiter: per-cycle vector table plus
// hand sequences, with a transfer scoreboard. Honours RB_ARB_STATS_EN.
module tb_ring_buffer_arbiter;
  import rb_arb_pkg::*;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int MB = 4;

  logic                   clk_i = 1'b0;
  logic                   rst_i;
  logic                   flush_i;
  logic [NR-1:0]          req_i;
  logic [NR-1:0]          ack_o;
  logic [NR-1:0][DW-1:0]  data_i;
  logic                   tx_o;
  logic                   tx_ack_i;
  logic [DW-1:0]          data_o;
  logic [NR-1:0]          grant_o;
`ifdef RB_ARB_STATS_EN
  logic [NR-1:0][STATS_W-1:0] xfer_cnt_o;
`endif

  ring_buffer_arbiter #(.DATA_SIZE(DW), .N_REQ(NR), .MAX_BURST(MB)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .req_i    (req_i),
    .ack_o    (ack_o),
    .data_i   (data_i),
    .tx_o     (tx_o),
    .tx_ack_i (tx_ack_i),
    .data_o   (data_o),
    .grant_o  (grant_o)
`ifdef RB_ARB_STATS_EN
    ,
    .xfer_cnt_o (xfer_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [NR-1:0] req;
    logic          ack;
    logic          flush;
    logic [7:0]    dat;
    logic [NR-1:0] exp_grant;
    logic [NR-1:0] exp_ack;
    logic          exp_tx;
  } vec_t;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } xfer_t;

  vec_t  vecs[$];
  xfer_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    exp_cnt[NR];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [NR-1:0] req, input logic ack, input logic flush,
                              input logic [7:0] dat, input logic [NR-1:0] eg,
                              input logic [NR-1:0] ea, input logic etx);
    vec_t v;
    v.req = req; v.ack = ack; v.flush = flush; v.dat = dat;
    v.exp_grant = eg; v.exp_ack = ea; v.exp_tx = etx;
    return v;
  endfunction

  function automatic logic [31:0] word(input int k, input logic [7:0] dat);
    return {8'(k), 16'h0000, dat};
  endfunction

  // Apply one cycle of inputs, check outputs mid-cycle, score the transfer.
  task automatic step(input vec_t v);
    logic [NR-1:0] exp_x;
    xfer_t e;
    req_i    = v.req;
    tx_ack_i = v.ack;
    flush_i  = v.flush;
    for (int k = 0; k < NR; k++) data_i[k] = word(k, v.dat);
    @(negedge clk_i);
    check("grant_o", 32'(grant_o), 32'(v.exp_grant));
    check("ack_o", 32'(ack_o), 32'(v.exp_ack));
    check("tx_o", 32'(tx_o), 32'(v.exp_tx));
    exp_x = v.exp_ack & v.req;
    if (v.exp_tx && (exp_x != '0)) begin
      for (int k = 0; k < NR; k++) begin
        if (exp_x[k]) begin
          e.idx  = k;
          e.data = word(k, v.dat);
          sb.push_back(e);
          exp_cnt[k]++;
        end
      end
    end
    if (tx_o && ((ack_o & req_i) != '0)) begin
      if (sb.size() == 0) begin
        check("unexpected_xfer", 32'(ack_o & req_i), 32'h0);
      end else begin
        e = sb.pop_front();
        check("xfer_data", data_o, e.data);
      end
    end
    check("sb_pending", 32'(sb.size()), 32'h0);
    sb.delete();
    if (v.flush) for (int k = 0; k < NR; k++) exp_cnt[k] = 0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_stats();
`ifdef RB_ARB_STATS_EN
    for (int k = 0; k < NR; k++) check("xfer_cnt_o", 32'(xfer_cnt_o[k]), 32'(exp_cnt[k]));
`endif
  endtask

  initial begin
    // Single requester on index 1, then a request on 1 and 3 proves the
    // pointer moved to 2 (index 3 wins).
    vecs.push_back(mk(4'b0010, 1, 0, 8'hA1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(4'b0010, 1, 0, 8'hA1, 4'b0010, 4'b0010, 1));
    vecs.push_back(mk(4'b0010, 1, 0, 8'hA2, 4'b0010, 4'b0010, 1));
    vecs.push_back(mk(4'b0010, 1, 0, 8'hA3, 4'b0010, 4'b0010, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 8'h00, 4'b0010, 4'b0010, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(4'b1010, 1, 0, 8'hB1, 4'b0000, 4'b0000, 0));
    vecs.push_back(mk(4'b1010, 1, 0, 8'hB2, 4'b1000, 4'b1000, 1));
    vecs.push_back(mk(4'b0000, 1, 0, 8'h00, 4'b1000, 4'b1000, 0));
    vecs.push_back(mk(4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    // Burst limit: 0 and 1 both held, grant alternates every MB transfers.
    for (int b = 0; b < 3; b++) begin
      logic [NR-1:0] g;
      g = (b == 1) ? 4'b0010 : 4'b0001;
      vecs.push_back(mk(4'b0011, 1, 0, 8'(8'h10 + 8'(b * 8)), 4'b0000, 4'b0000, 0));
      for (int t = 0; t < MB; t++)
        vecs.push_back(mk(4'b0011, 1, 0, 8'(8'h11 + 8'(b * 8 + t)), g, g, 1));
    end
    vecs.push_back(mk(4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));

    for (int k = 0; k < NR; k++) exp_cnt[k] = 0;
    rst_i    = 1'b1;
    flush_i  = 1'b0;
    req_i    = '1;
    tx_ack_i = 1'b1;
    for (int k = 0; k < NR; k++) data_i[k] = word(k, 8'hEE);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_tx", 32'(tx_o), 32'h0);
    check("rst_ack", 32'(ack_o), 32'h0);
    check("rst_grant", 32'(grant_o), 32'h0);
    check("rst_data", data_o, 32'h0);
    check_stats();
    rst_i = 1'b0;

    foreach (vecs[i]) step(vecs[i]);

    // Backpressure on requester 2 (pointer is 1): 5-cycle stall mid-burst.
    step(mk(4'b0100, 1, 0, 8'hC0, 4'b0000, 4'b0000, 0));
    for (int t = 0; t < 2; t++) step(mk(4'b0100, 1, 0, 8'(8'hC1 + 8'(t)), 4'b0100, 4'b0100, 1));
    for (int t = 0; t < 5; t++) step(mk(4'b0100, 0, 0, 8'hCF, 4'b0100, 4'b0000, 1));
    for (int t = 0; t < 2; t++) step(mk(4'b0100, 1, 0, 8'(8'hC3 + 8'(t)), 4'b0100, 4'b0100, 1));
    step(mk(4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));

    // Wrap-around from pointer 3: req3 first, then req0, then pointer is 1.
    step(mk(4'b1001, 1, 0, 8'hD0, 4'b0000, 4'b0000, 0));
    step(mk(4'b1001, 1, 0, 8'hD1, 4'b1000, 4'b1000, 1));
    step(mk(4'b0001, 1, 0, 8'hD2, 4'b1000, 4'b1000, 0));
    step(mk(4'b0001, 1, 0, 8'hD3, 4'b0000, 4'b0000, 0));
    step(mk(4'b0001, 1, 0, 8'hD4, 4'b0001, 4'b0001, 1));
    step(mk(4'b0000, 1, 0, 8'h00, 4'b0001, 4'b0001, 0));
    step(mk(4'b0011, 1, 0, 8'hD5, 4'b0000, 4'b0000, 0));
    step(mk(4'b0011, 1, 0, 8'hD6, 4'b0010, 4'b0010, 1));
    step(mk(4'b0000, 1, 0, 8'h00, 4'b0010, 4'b0010, 0));
    step(mk(4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    check_stats();

    // Flush after two transfers of req1 (pointer 2): pointer and counter reset.
    step(mk(4'b0010, 1, 0, 8'hE0, 4'b0000, 4'b0000, 0));
    for (int t = 0; t < 2; t++) step(mk(4'b0010, 1, 0, 8'(8'hE1 + 8'(t)), 4'b0010, 4'b0010, 1));
    step(mk(4'b0111, 1, 1, 8'hE3, 4'b0010, 4'b0000, 1));
    step(mk(4'b0110, 1, 0, 8'hE4, 4'b0000, 4'b0000, 0));
    for (int t = 0; t < MB; t++) step(mk(4'b0110, 1, 0, 8'(8'hE5 + 8'(t)), 4'b0010, 4'b0010, 1));
    step(mk(4'b0100, 1, 0, 8'hF0, 4'b0000, 4'b0000, 0));
    step(mk(4'b0100, 1, 0, 8'hF1, 4'b0100, 4'b0100, 1));
    check_stats();

    // Asynchronous reset between edges while req2 is mid-burst.
    #2 rst_i = 1'b1;
    #1;
    check("arst_tx", 32'(tx_o), 32'h0);
    check("arst_ack", 32'(ack_o), 32'h0);
    check("arst_grant", 32'(grant_o), 32'h0);
    check("arst_data", data_o, 32'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int k = 0; k < NR; k++) exp_cnt[k] = 0;
    check_stats();
    step(mk(4'b1001, 1, 0, 8'h90, 4'b0000, 4'b0000, 0));
    step(mk(4'b1001, 1, 0, 8'h91, 4'b0001, 4'b0001, 1));
    step(mk(4'b0000, 1, 0, 8'h00, 4'b0001, 4'b0001, 0));
    step(mk(4'b0000, 1, 0, 8'h00, 4'b0000, 4'b0000, 0));
    check_stats();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
